// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the memory-mapped UART.
//   - tx_state_t / rx_state_t : frame FSM state encodings
//   - DEFAULT_* constants     : default clock, line rate and FIFO depth
//   - calc_div()              : clocks per 16x oversample tick, rounded
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ   = 100_000_000;
  localparam int DEFAULT_BAUD       = 9600;
  localparam int DEFAULT_FIFO_DEPTH = 16;
  localparam int OVERSAMPLE         = 16;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // round(clk_freq / (baud * 16)); never below one clock per tick
  function automatic int calc_div(input int clk_freq, input int baud);
    int d;
    d = (clk_freq + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   push, din     : write strobe and data (ignored when full unless popping)
//   pop           : read strobe (ignored when empty)
//   dout          : registered head of queue, 0 when empty
//   empty, full   : registered occupancy flags
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic             empty_reg, full_reg;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop && !empty_reg;
  // a full FIFO still accepts a write when the same cycle frees a slot
  assign push_ok = push && (!full_reg || pop_ok);

  always_comb begin
    wr_ptr_next = push_ok ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next = pop_ok  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next  = count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    // Head is fetched one edge early so dout and the flags change together.
    // When the entry written now becomes the only entry it is not in the
    // array yet, so it is forwarded straight from din.
    if (count_next == '0)
      dout_next = '0;
    else if (push_ok && (count_reg == '0 || (count_reg == (AW+1)'(1) && pop_ok)))
      dout_next = din;
    else
      dout_next = mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      dout_reg   <= dout_next;
      empty_reg  <= (count_next == '0);
      full_reg   <= (count_next == (AW+1)'(DEPTH));
    end
  end

  assign dout  = dout_reg;
  assign empty = empty_reg;
  assign full  = full_reg;

endmodule

// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped 8N1 UART with TX and RX FIFOs.
//   clk, Rst         : system clock, synchronous active-high reset
//   tx_wen, uart_din : write strobe (acts on rising edge) and byte to send
//   rx_ren           : read strobe (acts on rising edge), pops RX head
//   uart_dout        : RX head, 0x00 when empty
//   rx_data_present  : RX FIFO not empty
//   tx_full          : TX FIFO full
//   rx_overrun       : sticky, a received byte was dropped
//   uart_rxd         : asynchronous serial input
//   uart_txd         : serial output, idles high
module mmio_uart
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       tx_wen,
  input  logic [7:0] uart_din,
  input  logic       rx_ren,
  output logic [7:0] uart_dout,
  output logic       rx_data_present,
  output logic       tx_full,
  output logic       rx_overrun,
  input  logic       uart_rxd,
  output logic       uart_txd
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  // strobe edge detect and oversample tick
  logic          tx_wen_q_reg, rx_ren_q_reg;
  logic          tx_push, rx_pop;
  logic [CW-1:0] baud_cnt_reg;
  logic          tick;

  assign tx_push = tx_wen && !tx_wen_q_reg;
  assign rx_pop  = rx_ren && !rx_ren_q_reg;
  assign tick    = (baud_cnt_reg == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (Rst) begin
      tx_wen_q_reg <= 1'b0;
      rx_ren_q_reg <= 1'b0;
      baud_cnt_reg <= '0;
    end else begin
      tx_wen_q_reg <= tx_wen;
      rx_ren_q_reg <= rx_ren;
      baud_cnt_reg <= tick ? '0 : baud_cnt_reg + 1'b1;
    end
  end

  // FIFOs
  logic [7:0] tx_head;
  logic       tx_empty, tx_pop;
  logic       rx_push, rx_empty, rx_full;
  logic [7:0] rx_shift_reg, rx_shift_next;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(Rst), .push(tx_push), .din(uart_din), .pop(tx_pop),
    .dout(tx_head), .empty(tx_empty), .full(tx_full)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(Rst), .push(rx_push), .din(rx_shift_reg), .pop(rx_pop),
    .dout(uart_dout), .empty(rx_empty), .full(rx_full)
  );

  assign rx_data_present = !rx_empty;

  // transmitter
  tx_state_t  tx_state_reg, tx_state_next;
  logic [3:0] tx_tick_reg, tx_tick_next;
  logic [2:0] tx_bit_reg, tx_bit_next;
  logic [7:0] tx_shift_reg, tx_shift_next;

  always_ff @(posedge clk) begin
    if (Rst) begin
      tx_state_reg <= TX_IDLE;
      tx_tick_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_tick_reg  <= tx_tick_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_tick_next  = tx_tick_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_pop        = 1'b0;
    uart_txd      = 1'b1;
    case (tx_state_reg)
      TX_IDLE: begin
        if (tick && !tx_empty) begin
          tx_pop        = 1'b1;
          tx_shift_next = tx_head;
          tx_tick_next  = '0;
          tx_state_next = TX_START;
        end
      end
      TX_START: begin
        uart_txd = 1'b0;
        if (tick) begin
          tx_tick_next = tx_tick_reg + 4'd1;
          if (tx_tick_reg == 4'd15) begin
            tx_bit_next   = '0;
            tx_state_next = TX_DATA;
          end
        end
      end
      TX_DATA: begin
        uart_txd = tx_shift_reg[0];
        if (tick) begin
          tx_tick_next = tx_tick_reg + 4'd1;
          if (tx_tick_reg == 4'd15) begin
            tx_shift_next = {1'b0, tx_shift_reg[7:1]};
            tx_bit_next   = tx_bit_reg + 3'd1;
            if (tx_bit_reg == 3'd7)
              tx_state_next = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          tx_tick_next = tx_tick_reg + 4'd1;
          if (tx_tick_reg == 4'd15) begin
            // back-to-back frames skip IDLE to keep the line saturated
            if (!tx_empty) begin
              tx_pop        = 1'b1;
              tx_shift_next = tx_head;
              tx_state_next = TX_START;
            end else begin
              tx_state_next = TX_IDLE;
            end
          end
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // receiver
  rx_state_t  rx_state_reg, rx_state_next;
  logic [3:0] rx_tick_reg, rx_tick_next;
  logic [2:0] rx_bit_reg, rx_bit_next;
  logic       rx_wait_high_reg, rx_wait_high_next;
  logic [1:0] rxd_sync_reg;
  logic       rx_s;
  logic       rx_overrun_reg;

  assign rx_s       = rxd_sync_reg[1];
  assign rx_overrun = rx_overrun_reg;

  always_ff @(posedge clk) begin
    if (Rst) begin
      rxd_sync_reg     <= 2'b11;
      rx_state_reg     <= RX_IDLE;
      rx_tick_reg      <= '0;
      rx_bit_reg       <= '0;
      rx_shift_reg     <= '0;
      rx_wait_high_reg <= 1'b0;
      rx_overrun_reg   <= 1'b0;
    end else begin
      rxd_sync_reg     <= {rxd_sync_reg[0], uart_rxd};
      rx_state_reg     <= rx_state_next;
      rx_tick_reg      <= rx_tick_next;
      rx_bit_reg       <= rx_bit_next;
      rx_shift_reg     <= rx_shift_next;
      rx_wait_high_reg <= rx_wait_high_next;
      // the FIFO itself drops the byte; here we only remember that it did
      if (rx_push && rx_full && !rx_pop)
        rx_overrun_reg <= 1'b1;
    end
  end

  always_comb begin
    rx_state_next     = rx_state_reg;
    rx_tick_next      = rx_tick_reg;
    rx_bit_next       = rx_bit_reg;
    rx_shift_next     = rx_shift_reg;
    rx_wait_high_next = rx_wait_high_reg;
    rx_push           = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        // after a framing error the line may still be low; do not treat
        // that as a new start bit
        if (rx_wait_high_reg) begin
          if (rx_s)
            rx_wait_high_next = 1'b0;
        end else if (!rx_s) begin
          rx_tick_next  = '0;
          rx_state_next = RX_START;
        end
      end
      RX_START: begin
        // 8 ticks lands mid start bit; from here every 16 ticks is mid-bit
        if (tick) begin
          rx_tick_next = rx_tick_reg + 4'd1;
          if (rx_tick_reg == 4'd7) begin
            if (rx_s) begin
              rx_state_next = RX_IDLE;
            end else begin
              rx_tick_next  = '0;
              rx_bit_next   = '0;
              rx_state_next = RX_DATA;
            end
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_tick_next = rx_tick_reg + 4'd1;
          if (rx_tick_reg == 4'd15) begin
            rx_shift_next = {rx_s, rx_shift_reg[7:1]};
            rx_bit_next   = rx_bit_reg + 3'd1;
            if (rx_bit_reg == 3'd7)
              rx_state_next = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          rx_tick_next = rx_tick_reg + 4'd1;
          if (rx_tick_reg == 4'd15) begin
            rx_state_next = RX_IDLE;
            if (rx_s)
              rx_push = 1'b1;
            else
              rx_wait_high_next = 1'b1;
          end
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart.sv
// tb_mmio_uart: self-checking bench for mmio_uart at a fast line rate
// (3 clocks per tick, 48 clocks per bit) so whole frames fit the run.
module tb_mmio_uart;

  localparam int CLK_FREQ = 4_800_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 16;
  localparam int DIV      = 3;
  localparam int BIT      = 16 * DIV;

  logic       clk = 1'b0;
  logic       Rst;
  logic       tx_wen;
  logic [7:0] uart_din;
  logic       rx_ren;
  logic [7:0] uart_dout;
  logic       rx_data_present;
  logic       tx_full;
  logic       rx_overrun;
  logic       uart_rxd;
  logic       uart_txd;
  logic       loopback;
  logic       rxd_drv;

  int total = 0;
  int bad   = 0;

  logic [7:0] tx_seen [$];
  logic [7:0] exp_q [$];
  logic [7:0] mon_byte;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       glitch;
    logic       exp_present;
    logic [7:0] exp_dout;
  } rx_vec_t;

  rx_vec_t vecs [7];

  always #5 clk = ~clk;

  assign uart_rxd = loopback ? uart_txd : rxd_drv;

  mmio_uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .Rst(Rst), .tx_wen(tx_wen), .uart_din(uart_din),
    .rx_ren(rx_ren), .uart_dout(uart_dout),
    .rx_data_present(rx_data_present), .tx_full(tx_full),
    .rx_overrun(rx_overrun), .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );

  // Line monitor: decodes every well-formed frame seen on uart_txd.
  initial begin
    forever begin
      @(negedge clk);
      if (!Rst && uart_txd === 1'b0) begin
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          mon_byte[i] = uart_txd;
        end
        repeat (BIT) @(negedge clk);
        if (uart_txd === 1'b1)
          tx_seen.push_back(mon_byte);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    uart_din = b;
    tx_wen   = 1'b1;
    @(negedge clk);
    tx_wen   = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_byte();
    rx_ren = 1'b1;
    @(negedge clk);
    rx_ren = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rxd_drv = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      cyc(BIT);
    end
    rxd_drv = stop;
    cyc(BIT);
    rxd_drv = 1'b1;
    cyc(2 * BIT);
  endtask

  task automatic wait_txd_low(input int max);
    for (int i = 0; i < max && uart_txd !== 1'b0; i++) @(negedge clk);
  endtask

  task automatic wait_seen(input int n, input int max);
    for (int i = 0; i < max && tx_seen.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_present(input int max);
    for (int i = 0; i < max && !rx_data_present; i++) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int n;
    logic [7:0] b;
    logic [7:0] sent [$];

    vecs[0] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h00};  // framing error
    vecs[1] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h81};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};  // short low glitch
    vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF};
    vecs[5] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'h00};  // framing error
    vecs[6] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A};

    Rst = 1'b1; tx_wen = 1'b0; rx_ren = 1'b0; uart_din = 8'h00;
    loopback = 1'b0; rxd_drv = 1'b1;
    cyc(3);
    chk("rst_txd", uart_txd, 1);
    chk("rst_dout", uart_dout, 8'h00);
    chk("rst_present", rx_data_present, 0);
    chk("rst_full", tx_full, 0);
    chk("rst_overrun", rx_overrun, 0);
    Rst = 1'b0;
    cyc(5);

    // 0x55: alternating levels, each exactly one bit period wide
    tx_seen.delete();
    write_byte(8'h55);
    wait_txd_low(4 * DIV + 8);
    for (int i = 0; i < 9; i++) begin
      cnt = 0;
      while (uart_txd === ((i % 2) == 1) && cnt < 2 * BIT) begin
        cnt++;
        @(negedge clk);
      end
      chk($sformatf("tx55_width%0d", i), cnt, BIT);
    end
    cnt = 0;
    for (int i = 0; i < 3 * BIT; i++) begin
      if (uart_txd !== 1'b1) cnt++;
      @(negedge clk);
    end
    chk("tx55_stop_idle_low_cycles", cnt, 0);
    chk("tx55_seen_n", tx_seen.size(), 1);
    if (tx_seen.size() > 0) chk("tx55_seen_byte", tx_seen[0], 8'h55);

    // driven RX frames from the vector table
    foreach (vecs[k]) begin
      if (vecs[k].glitch) begin
        rxd_drv = 1'b0;
        cyc(4);
        rxd_drv = 1'b1;
        cyc(3 * BIT);
      end else begin
        send_frame(vecs[k].data, vecs[k].stop_bit);
      end
      chk($sformatf("rxvec%0d_present", k), rx_data_present, vecs[k].exp_present);
      chk($sformatf("rxvec%0d_dout", k), uart_dout, vecs[k].exp_dout);
      if (vecs[k].exp_present) begin
        pop_byte();
        chk($sformatf("rxvec%0d_drain", k), rx_data_present, 0);
      end
    end

    // loopback A3, 0F and two reads
    loopback = 1'b1;
    write_byte(8'hA3);
    write_byte(8'h0F);
    wait_present(12 * BIT);
    chk("lb_present1", rx_data_present, 1);
    chk("lb_dout1", uart_dout, 8'hA3);
    cyc(12 * BIT);
    chk("lb_head_kept", uart_dout, 8'hA3);
    pop_byte();
    chk("lb_present2", rx_data_present, 1);
    chk("lb_dout2", uart_dout, 8'h0F);
    pop_byte();
    chk("lb_present3", rx_data_present, 0);
    chk("lb_dout3", uart_dout, 8'h00);
    pop_byte();
    chk("lb_pop_empty", rx_data_present, 0);

    // a held read strobe pops only once
    write_byte(8'h11);
    write_byte(8'h22);
    wait_present(12 * BIT);
    cyc(12 * BIT);
    rx_ren = 1'b1;
    cyc(5);
    rx_ren = 1'b0;
    cyc(1);
    chk("held_ren_present", rx_data_present, 1);
    chk("held_ren_dout", uart_dout, 8'h22);
    pop_byte();
    chk("held_ren_drain", rx_data_present, 0);

    // random bytes through the loop, checked against an in-order queue
    tx_seen.delete();
    exp_q.delete();
    n = $urandom_range(4, 10);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      write_byte(b);
      exp_q.push_back(b);
      cyc($urandom_range(0, 2 * BIT));
    end
    wait_seen(n, (n + 2) * 10 * BIT);
    cyc(BIT);
    chk("rand_seen_n", tx_seen.size(), n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rand_present%0d", i), rx_data_present, 1);
      chk($sformatf("rand_dout%0d", i), uart_dout, exp_q[i]);
      if (i < tx_seen.size()) chk($sformatf("rand_line%0d", i), tx_seen[i], exp_q[i]);
      pop_byte();
    end
    chk("rand_empty", rx_data_present, 0);

    // TX full, dropped write, RX overrun
    tx_seen.delete();
    sent.delete();
    chk("ovr_pre", rx_overrun, 0);
    write_byte(8'hC0);
    sent.push_back(8'hC0);
    wait_txd_low(4 * DIV + 8);
    for (int i = 0; i < 16; i++) begin
      write_byte(8'h10 + 8'(i));
      sent.push_back(8'h10 + 8'(i));
      if (i == 14) chk("full_after15", tx_full, 0);
      if (i == 15) chk("full_after16", tx_full, 1);
    end
    write_byte(8'hEE);
    chk("full_after_drop", tx_full, 1);
    wait_seen(17, 20 * 10 * BIT);
    cyc(BIT);
    cyc(2 * BIT);
    chk("ovr_seen_n", tx_seen.size(), 17);
    chk("ovr_flag", rx_overrun, 1);
    chk("ovr_tx_full_clear", tx_full, 0);
    for (int i = 0; i < 17; i++)
      if (i < tx_seen.size()) chk($sformatf("ovr_line%0d", i), tx_seen[i], sent[i]);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("ovr_dout%0d", i), uart_dout, sent[i]);
      pop_byte();
    end
    chk("ovr_empty", rx_data_present, 0);
    chk("ovr_sticky", rx_overrun, 1);

    // reset in the middle of a data bit
    loopback = 1'b0;
    write_byte(8'h00);
    write_byte(8'h77);
    wait_txd_low(4 * DIV + 8);
    cyc(BIT + 3 * BIT + BIT / 2);
    chk("mid_txd_low", uart_txd, 0);
    Rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_txd", uart_txd, 1);
    chk("mid_rst_full", tx_full, 0);
    chk("mid_rst_overrun", rx_overrun, 0);
    chk("mid_rst_present", rx_data_present, 0);
    chk("mid_rst_dout", uart_dout, 8'h00);
    Rst = 1'b0;
    cyc(12 * BIT);
    tx_seen.delete();
    write_byte(8'h96);
    wait_seen(1, 14 * BIT);
    cyc(3 * BIT);
    chk("post_rst_seen_n", tx_seen.size(), 1);
    if (tx_seen.size() > 0) chk("post_rst_byte", tx_seen[0], 8'h96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_uart.md
MMIO_UART -- requirements
Module: mmio_uart

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, entries per FIFO, power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port Rst, input, 1, reset: synchronous and active-high.
REQ-006 SHALL have port tx_wen, input, 1, write strobe from the memory controller (MMIO address 0xAAAAA400).
REQ-007 SHALL have port uart_din, input, 8, byte to transmit.
REQ-008 SHALL have port rx_ren, input, 1, read strobe from the memory controller (MMIO address 0xAAAAA400).
REQ-009 SHALL have port uart_dout, output, 8, head of the RX FIFO.
REQ-010 SHALL have port rx_data_present, output, 1, RX FIFO not empty.
REQ-011 SHALL have port tx_full, output, 1, TX FIFO full.
REQ-012 SHALL have port rx_overrun, output, 1, sticky flag: a received byte was lost.
REQ-013 SHALL have port uart_rxd, input, 1, asynchronous serial input.
REQ-014 SHALL have port uart_txd, output, 1, serial output.

Function
REQ-015 SHALL qualify each strobe on its rising edge: tx_wen high with a registered previous value of 0 is one push; rx_ren likewise is one pop; a held strobe acts once.
REQ-016 SHALL push uart_din on a qualified tx_wen when TX FIFO not full; when full, the byte is discarded and FIFO state is unchanged.
REQ-017 SHALL present the RX head on uart_dout as first-word-fall-through, valid in the same cycle rx_data_present is 1; uart_dout = 0x00 when empty.
REQ-018 SHALL pop the RX FIFO at the clock edge ending a cycle with a qualified rx_ren when non-empty; pop on empty is ignored.
REQ-019 SHALL update rx_data_present and tx_full registered, in the cycle after the push/pop or receive completion that changes them.
REQ-020 SHALL allow a push and a pop on the same FIFO in one cycle, including when the FIFO is full; occupancy is unchanged and no data is lost.
REQ-021 SHALL generate a 16x oversample tick every DIV = round(CLK_FREQ/(BAUD*16)) clocks (651 at defaults) from a free-running counter that wraps DIV-1 -> 0.
REQ-022 SHALL use 8N1 framing, LSB first, one bit period = 16 ticks.
REQ-023 TX FSM SHALL have states IDLE, START, DATA, STOP; IDLE -> START on the next tick when TX FIFO is non-empty, popping the byte; START, each DATA bit and STOP each last 16 ticks; STOP -> IDLE, or directly -> START if the FIFO is non-empty; uart_txd=1 in IDLE/STOP, 0 in START.
REQ-024 SHALL pass uart_rxd through a 2-flop synchronizer, both flops reset to 1.
REQ-025 RX FSM SHALL have states IDLE, START, DATA, STOP; IDLE -> START on a synchronized 0; START re-samples at tick 8 and returns to IDLE if the line is 1 (glitch); DATA samples each bit at its 16th tick; STOP samples at its 16th tick.
REQ-026 SHALL push the byte to the RX FIFO only if the stop bit is 1; a 0 stop bit discards the byte and the FSM waits in IDLE for the line to return to 1.
REQ-027 SHALL set rx_overrun and drop the byte when a valid byte completes while the RX FIFO is full and no pop occurs in that cycle; the flag clears only on Rst.

Reset
REQ-028 SHALL on Rst, on the next edge: empty both FIFOs, set both FSMs to IDLE, clear the baud counter and edge-detect registers, drive uart_txd=1, uart_dout=0x00, rx_data_present=0, tx_full=0 and rx_overrun=0.
REQ-029 SHALL abort any frame in progress on Rst; the partially sent or received byte is lost.

Structure
REQ-030 SHALL place the TX/RX FSM state enums and the default CLK_FREQ/BAUD/FIFO_DEPTH constants in shared package uart_pkg.
REQ-031 SHALL implement both FIFOs as two instances of one sub-module uart_fifo (synchronous, FWFT, parameterized width/depth, full/empty flags).

Verification
REQ-032 Write 0x55 at defaults -> uart_txd shows 0,1,0,1,0,1,0,1,0,1 with each bit 10416 clk wide, then idles at 1.
REQ-033 Loop uart_txd to uart_rxd and write 0xA3, then 0x0F -> rx_data_present=1 with uart_dout=0xA3; one rx_ren pulse -> uart_dout=0x0F; second pulse -> rx_data_present=0, uart_dout=0x00.
REQ-034 17 tx_wen pulses with the line held busy -> tx_full=1 after the 16th; 17th byte never appears on uart_txd.
REQ-035 Drive a frame 0x3C on uart_rxd with stop bit 0 -> no push, rx_data_present stays 0; a following good frame 0x81 is received.
REQ-036 Hold rx_ren high for 5 cycles with 2 bytes queued -> exactly one pop; fill the RX FIFO with 17 bytes without reads -> rx_overrun=1 and the first 16 bytes are intact.
REQ-037 Assert Rst mid-DATA of TX -> uart_txd=1 on the next edge and all flags 0; a new write afterwards transmits a clean frame.
